ft601_tx_packer: RTL

//  Transmit half of the USB3 FT601 bridge: accepts the command_processor byte stream (o_tvalid/o_tdata/o_tlast),

---
 rtl/ft601_tx_packer.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ft601_tx_packer.sv
`timescale 1ns/1ps
// ft601_tx_packer
// Transmit half of the FT601 bridge, ftdi_clk domain. Packs an 8-bit byte
// stream little-endian into 32-bit words with byte enables, buffers the words
// in a small FIFO and writes them to the FT601 TX FIFO, one word per clock.
// Optional feature macro: FT601_TX_TIMEOUT_FLUSH_EN. When it is defined, a
// partial word that sees no input for FLUSH_TIMEOUT cycles is pushed as if the
// last byte had carried s_tlast. When it is undefined, partial words leave only
// on s_tlast and no timeout counter is built.
module ft601_tx_packer #(
    parameter int FIFO_DEPTH    = 16,
    parameter int FLUSH_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic [7:0]  s_tdata,
    input  logic        s_tlast,
    input  logic        ftdi_txe_n,
    output logic        ftdi_wr_n,
    output logic [31:0] ftdi_data_out,
    output logic [3:0]  ftdi_be_out,
    output logic        ftdi_data_oe,
    output logic        tx_busy,
    output logic [31:0] words_sent
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);

    // Reject configurations the FIFO pointer arithmetic cannot handle.
    if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (FLUSH_TIMEOUT < 1)) begin : g_param_check
        $error("ft601_tx_packer: FIFO_DEPTH must be a power of 2 >= 4 and FLUSH_TIMEOUT >= 1");
    end

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    // Packer registers
    logic [31:0]   r_pack_data;
    logic [3:0]    r_pack_be;
    logic [1:0]    r_idx;
    logic          r_s_tready;

    // Word FIFO
    logic [31:0]   r_mem_data [FIFO_DEPTH];
    logic [3:0]    r_mem_be   [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    // Write side
    state_t        r_state;
    logic          r_wr_n;
    logic [31:0]   r_data_out;
    logic [3:0]    r_be_out;
    logic          r_oe;
    logic          r_tx_busy;
    logic [31:0]   r_words_sent;

    logic          w_accept;
    logic          w_full;
    logic          w_empty;
    logic [31:0]   w_merge_data;
    logic [3:0]    w_merge_be;
    logic          w_word_done;
    logic          w_flush;
    logic          w_push;
    logic [31:0]   w_push_data;
    logic [3:0]    w_push_be;
    logic          w_pop;
    logic          w_more;
    logic [CW-1:0] w_count_nxt;
    logic [1:0]    w_idx_nxt;
    logic          w_write_nxt;
    logic [AW-1:0] w_rptr_p1;

    // s_tready is a registered copy of "FIFO not full", so an accepted word
    // always has a free slot on the edge it completes.
    assign w_accept    = s_tvalid & r_s_tready;
    assign w_full      = (r_count == C_DEPTH);
    assign w_empty     = (r_count == {CW{1'b0}});
    assign w_word_done = w_accept & ((r_idx == 2'd3) | s_tlast);
    assign w_push      = w_word_done | w_flush;
    assign w_push_data = w_accept ? w_merge_data : r_pack_data;
    assign w_push_be   = w_accept ? w_merge_be : r_pack_be;
    assign w_pop       = (r_state == ST_WRITE) & ~ftdi_txe_n;
    assign w_more      = (r_count >= CW'(2));
    assign w_rptr_p1   = r_rptr + AW'(1);
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    // Merge the incoming byte into its little-endian lane of the word being built.
    always_comb begin
        w_merge_data = r_pack_data;
        w_merge_be   = r_pack_be;
        case (r_idx)
            2'd0: begin
                w_merge_data[7:0] = s_tdata;
                w_merge_be[0]     = 1'b1;
            end
            2'd1: begin
                w_merge_data[15:8] = s_tdata;
                w_merge_be[1]      = 1'b1;
            end
            2'd2: begin
                w_merge_data[23:16] = s_tdata;
                w_merge_be[2]       = 1'b1;
            end
            2'd3: begin
                w_merge_data[31:24] = s_tdata;
                w_merge_be[3]       = 1'b1;
            end
            default: begin
                w_merge_data = r_pack_data;
                w_merge_be   = r_pack_be;
            end
        endcase
    end

    // Next byte index and next write-state, used to keep tx_busy registered yet exact.
    always_comb begin
        if (w_push) begin
            w_idx_nxt = 2'd0;
        end else if (w_accept) begin
            w_idx_nxt = r_idx + 2'd1;
        end else begin
            w_idx_nxt = r_idx;
        end
        if (r_state == ST_IDLE) begin
            w_write_nxt = ~w_empty & ~ftdi_txe_n;
        end else begin
            w_write_nxt = ~(w_pop & ~w_more);
        end
    end

`ifdef FT601_TX_TIMEOUT_FLUSH_EN
    localparam int TOW = $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [TOW-1:0] C_TIMEOUT = TOW'(FLUSH_TIMEOUT);

    logic [TOW-1:0] r_to_cnt;

    // A stalled partial word is pushed once the idle count saturates and a slot is free.
    assign w_flush = (r_to_cnt == C_TIMEOUT) & (r_idx != 2'd0) & ~w_full & ~w_accept;

    // Count idle cycles while a partial word is held; any accepted byte restarts the count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_to_cnt <= {TOW{1'b0}};
        end else if (w_accept || (r_idx == 2'd0) || w_flush) begin
            r_to_cnt <= {TOW{1'b0}};
        end else if (!s_tvalid && (r_to_cnt != C_TIMEOUT)) begin
            r_to_cnt <= r_to_cnt + TOW'(1);
        end
    end
`else
    assign w_flush = 1'b0;
`endif

    // Byte packer: collect lanes, clear the assembly word whenever it is pushed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pack_data <= 32'h0000_0000;
            r_pack_be   <= 4'b0000;
            r_idx       <= 2'd0;
        end else begin
            r_idx <= w_idx_nxt;
            if (w_push) begin
                r_pack_data <= 32'h0000_0000;
                r_pack_be   <= 4'b0000;
            end else if (w_accept) begin
                r_pack_data <= w_merge_data;
                r_pack_be   <= w_merge_be;
            end
        end
    end

    // FIFO storage; contents are qualified by the pointers so need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wptr] <= w_push_data;
            r_mem_be[r_wptr]   <= w_push_be;
        end
    end

    // FIFO pointers, occupancy, input handshake and busy flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr     <= {AW{1'b0}};
            r_rptr     <= {AW{1'b0}};
            r_count    <= {CW{1'b0}};
            r_s_tready <= 1'b0;
            r_tx_busy  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= w_rptr_p1;
            end
            r_count    <= w_count_nxt;
            r_s_tready <= (w_count_nxt != C_DEPTH);
            r_tx_busy  <= (w_idx_nxt != 2'd0) | (w_count_nxt != {CW{1'b0}}) | w_write_nxt;
        end
    end

    // Write FSM: present the FIFO head, pop on FT601 accept, stream back-to-back.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_wr_n       <= 1'b1;
            r_data_out   <= 32'h0000_0000;
            r_be_out     <= 4'b0000;
            r_oe         <= 1'b0;
            r_words_sent <= 32'h0000_0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty && !ftdi_txe_n) begin
                        r_data_out <= r_mem_data[r_rptr];
                        r_be_out   <= r_mem_be[r_rptr];
                        r_oe       <= 1'b1;
                        r_wr_n     <= 1'b0;
                        r_state    <= ST_WRITE;
                    end else begin
                        r_oe   <= 1'b0;
                        r_wr_n <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    // With txe_n high the word stays on the pads untouched.
                    if (!ftdi_txe_n) begin
                        r_words_sent <= r_words_sent + 32'd1;
                        if (w_more) begin
                            r_data_out <= r_mem_data[w_rptr_p1];
                            r_be_out   <= r_mem_be[w_rptr_p1];
                        end else begin
                            r_wr_n  <= 1'b1;
                            r_oe    <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_wr_n  <= 1'b1;
                    r_oe    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_tready      = r_s_tready;
    assign ftdi_wr_n     = r_wr_n;
    assign ftdi_data_out = r_data_out;
    assign ftdi_be_out   = r_be_out;
    assign ftdi_data_oe  = r_oe;
    assign tx_busy       = r_tx_busy;
    assign words_sent    = r_words_sent;

endmodule
